// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button conditioner: per-channel debounce states
// and the default debounce length.
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/btn_conditioner_debounce_ch.sv
// One button channel: two-flop synchronizer feeding a press/release debounce FSM.
// pulse_o is the next-cycle press strobe; the top registers it after selection.
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cntInc;
    logic          level_q, level_d;
    logic          pulse_d;
    logic          sample;

    assign sample = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // The counter holds how many consecutive samples have disagreed with the
    // accepted level; any agreeing sample throws the candidate change away.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        cntInc  = cnt_q + CW'(1);
        case (state_q)
            IDLE: begin
                if (sample) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sample) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cntInc == CNT_DONE) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cntInc;
                end
            end
            PRESSED: begin
                if (!sample) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sample) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cntInc == CNT_DONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cntInc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o = level_q;
    assign pulse_o = pulse_d;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces N_BTN raw buttons into levels and one-cycle press strobes.
// Define BTN_ONEHOT_PULSE_EN to keep only the lowest-index strobe per cycle.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N_BTN           = 6,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_IN,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PULSE,
    output logic             ANY_PULSE
);

    logic [N_BTN-1:0] pulseRaw;
    logic [N_BTN-1:0] pulseSel;
    logic [N_BTN-1:0] pulse_q;
    logic             any_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i  (CLK),
            .rst_i  (RST),
            .btn_i  (BTN_IN[i]),
            .level_o(BTN_LEVEL[i]),
            .pulse_o(pulseRaw[i])
        );
    end

`ifdef BTN_ONEHOT_PULSE_EN
    // Two's-complement trick isolates the lowest set bit.
    assign pulseSel = pulseRaw & (~pulseRaw + N_BTN'(1));
`else
    assign pulseSel = pulseRaw;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            pulse_q <= '0;
            any_q   <= 1'b0;
        end else begin
            pulse_q <= pulseSel;
            any_q   <= |pulseSel;
        end
    end

    assign BTN_PULSE = pulse_q;
    assign ANY_PULSE = any_q;

endmodule
